// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map, FSM states, bit indices.
// The optional parity feature is built only when WB_UART_TX_PARITY_EN is defined.
package wb_uart_tx_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int CTRL_PAR_EN_BIT  = 0;
  localparam int CTRL_PAR_ODD_BIT = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // A divider of zero still yields a one-clock bit period.
  function automatic logic [15:0] eff_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic slave bus bundle used by wb_uart_tx.
interface wb_uart_tx_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_uart_tx_core.sv
// UART serialiser: FSM, bit-period counter and shift register for one 8N1 (optionally 8P1) frame.
module uart_tx_core
  import wb_uart_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [7:0]  data_i,
  input  logic [15:0] div_i,
  input  logic        par_en_i,
  input  logic        par_odd_i,
  output logic        busy_o,
  output logic        tx_o
);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        par_q, par_d;
  logic        par_en_q, par_en_d;
  logic        tx_q, tx_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;
    if (state_q == IDLE) begin
      // Divider and parity mode are frozen for the whole frame at its start.
      if (start_i) begin
        state_d  = START;
        reload_d = eff_period(div_i);
        cnt_d    = eff_period(div_i) - 16'd1;
        sh_d     = data_i;
        bit_d    = 3'd0;
        par_d    = (^data_i) ^ par_odd_i;
        par_en_d = par_en_i;
        tx_d     = 1'b0;
      end
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = reload_q - 16'd1;
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
        DATA: begin
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_q : 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      reload_q <= 16'd1;
      sh_q     <= 8'd0;
      bit_q    <= 3'd0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave front end for the UART transmitter: address decode, one-cycle ack, DATA/STATUS/DIV registers.
// Defining WB_UART_TX_PARITY_EN adds the CTRL register (parity enable / odd) at offset 0x0C.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] DIV_RESET = 16'd347
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  wb_uart_tx_if.slave  wbs,
  output logic         uart_tx_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] div_q, div_d;
  logic        par_en_q, par_odd_q;
  logic        busy, hit, req, wr, start;
  logic [3:0]  off;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit   = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign off   = wbs.wbs_adr_i[3:0];
  assign req   = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & ~ack_q;
  // Writes take effect in the ack cycle while the master still holds the bus.
  assign wr    = ack_q & wbs.wbs_we_i;
  assign start = wr & (off == OFF_DATA) & wbs.wbs_sel_i[0] & ~busy;

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_STATUS: rdata[STATUS_BUSY_BIT] = busy;
      OFF_DIV:    rdata[15:0] = div_q;
`ifdef WB_UART_TX_PARITY_EN
      OFF_CTRL: begin
        rdata[CTRL_PAR_EN_BIT]  = par_en_q;
        rdata[CTRL_PAR_ODD_BIT] = par_odd_q;
      end
`endif
      default:    rdata = 32'd0;
    endcase
  end

  always_comb begin
    ack_d = req;
    dat_d = (req & ~wbs.wbs_we_i) ? rdata : 32'd0;
    div_d = div_q;
    if (wr && off == OFF_DIV) begin
      if (wbs.wbs_sel_i[0]) div_d[7:0]  = wbs.wbs_dat_i[7:0];
      if (wbs.wbs_sel_i[1]) div_d[15:8] = wbs.wbs_dat_i[15:8];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
      div_q <= DIV_RESET;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      div_q <= div_d;
    end
  end

`ifdef WB_UART_TX_PARITY_EN
  logic par_en_d, par_odd_d;

  always_comb begin
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    if (wr && off == OFF_CTRL && wbs.wbs_sel_i[0]) begin
      par_en_d  = wbs.wbs_dat_i[CTRL_PAR_EN_BIT];
      par_odd_d = wbs.wbs_dat_i[CTRL_PAR_ODD_BIT];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
    end
  end
`else
  assign par_en_q  = 1'b0;
  assign par_odd_q = 1'b0;
`endif

  assign unused_bits = ^{wbs.wbs_sel_i[3:2], wbs.wbs_dat_i[31:16]};

  uart_tx_core u_core (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (start),
    .data_i    (wbs.wbs_dat_i[7:0]),
    .div_i     (div_q),
    .par_en_i  (par_en_q),
    .par_odd_i (par_odd_q),
    .busy_o    (busy),
    .tx_o      (uart_tx_o)
  );

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: reset, framing, busy drop, DIV timing, async reset and parity/CTRL.
module tb_wb_uart_tx;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic uart_tx;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] BASE = 32'h3000_0000;

  wb_uart_tx_if wbs();

  wb_uart_tx dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .wbs       (wbs),
    .uart_tx_o (uart_tx)
  );

  always #5 clk = ~clk;

  // Expected line level i cycles into a frame: start, LSB-first data, optional parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int div, input int i,
                                   input logic par_en, input logic par_odd);
    int b;
    b = i / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_en && b == 9) return (^d) ^ par_odd;
    return 1'b1;
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = wd;
    wbs.wbs_sel_i = sel;
    acked = 1'b0;
    rd    = 32'd0;
    for (int k = 0; k < 4 && !acked; k++) begin
      @(posedge clk); #1;
      if (wbs.wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        rd    = wbs.wbs_dat_o;
      end
    end
    if (acked) begin
      @(posedge clk); #1;
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        ak;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    checks++; if (wbs.wbs_ack_o !== 1'b0 || wbs.wbs_dat_o !== 32'd0) begin
      errors++; $display("FAIL reset_bus ack=%b dat=%h exp ack=0 dat=0", wbs.wbs_ack_o, wbs.wbs_dat_o); end
    rstn = 1'b1;
    @(posedge clk); #1;
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
    checks++; if (ak !== 1'b1 || rd !== 32'd347) begin errors++; $display("FAIL reset_div got=%0d ack=%b exp=347", rd, ak); end
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
    checks++; if (ak !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL reset_status got=%h ack=%b exp=0", rd, ak); end
    wb_xfer(1'b0, BASE, 32'd0, 4'hF, rd, ak);
    checks++; if (ak !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL read_data got=%h ack=%b exp=0", rd, ak); end
    wb_xfer(1'b0, BASE + 32'h1, 32'd0, 4'hF, rd, ak);
    checks++; if (ak !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h ack=%b exp=0 ack=1", rd, ak); end
    wb_xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, rd, ak);
    checks++; if (ak !== 1'b0) begin errors++; $display("FAIL nondecoded_ack got=%b exp=0", ak); end
  endtask

  task automatic test_frame();
    logic [31:0] rd;
    logic        ak;
    int          bad;
    wb_xfer(1'b1, BASE + 32'h8, 32'd4, 4'h3, rd, ak);
    wb_xfer(1'b1, BASE, 32'hA5, 4'h1, rd, ak);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      checks++; if (uart_tx !== exp_bit(8'hA5, 4, i, 1'b0, 1'b0)) begin
        errors++; $display("FAIL frame_a5_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'hA5, 4, i, 1'b0, 1'b0)); end
      if (dut.busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL frame_busy_high low_cycles=%0d exp=0", bad); end
    checks++; if (dut.busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++; $display("FAIL frame_end busy=%b tx=%b exp busy=0 tx=1", dut.busy, uart_tx); end
  endtask

  task automatic test_write_while_busy();
    logic [31:0] rd;
    logic        ak;
    int          lows;
    wb_xfer(1'b1, BASE, 32'hA5, 4'h1, rd, ak);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          checks++; if (uart_tx !== exp_bit(8'hA5, 4, i, 1'b0, 1'b0)) begin
            errors++; $display("FAIL busy_wr_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'hA5, 4, i, 1'b0, 1'b0)); end
          @(posedge clk); #1;
        end
      end
      begin
        logic [31:0] rd2;
        logic        ak2;
        repeat (6) @(posedge clk);
        #1;
        wb_xfer(1'b1, BASE, 32'h12, 4'h1, rd2, ak2);
        checks++; if (ak2 !== 1'b1) begin errors++; $display("FAIL busy_wr_ack got=%b exp=1", ak2); end
        wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd2, ak2);
        checks++; if (rd2 !== 32'd1) begin errors++; $display("FAIL status_busy got=%h exp=1", rd2); end
      end
    join
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL busy_wr_drop got=%b exp=0", dut.busy); end
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (uart_tx !== 1'b1) lows++;
      @(posedge clk); #1;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL busy_wr_dropped low_cycles=%0d exp=0", lows); end
  endtask

  task automatic test_div_midframe();
    logic [31:0] rd;
    logic        ak;
    wb_xfer(1'b1, BASE + 32'h8, 32'd4, 4'h3, rd, ak);
    wb_xfer(1'b1, BASE, 32'h00, 4'h1, rd, ak);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          checks++; if (uart_tx !== exp_bit(8'h00, 4, i, 1'b0, 1'b0)) begin
            errors++; $display("FAIL midframe_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'h00, 4, i, 1'b0, 1'b0)); end
          @(posedge clk); #1;
        end
      end
      begin
        logic [31:0] rd2;
        logic        ak2;
        repeat (18) @(posedge clk);
        #1;
        wb_xfer(1'b1, BASE + 32'h8, 32'd8, 4'h3, rd2, ak2);
      end
    join
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL midframe_end busy=%b exp=0", dut.busy); end
    wb_xfer(1'b1, BASE, 32'hFF, 4'h1, rd, ak);
    for (int i = 0; i < 80; i++) begin
      checks++; if (uart_tx !== exp_bit(8'hFF, 8, i, 1'b0, 1'b0)) begin
        errors++; $display("FAIL div8_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'hFF, 8, i, 1'b0, 1'b0)); end
      @(posedge clk); #1;
    end
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL div8_end busy=%b exp=0", dut.busy); end
  endtask

  task automatic test_div_lanes();
    logic [31:0] rd;
    logic        ak;
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_1234, 4'hF, rd, ak);
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL div_full got=%h exp=00001234", rd); end
    wb_xfer(1'b1, BASE + 32'h8, 32'h0000_ABCD, 4'h2, rd, ak);
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
    checks++; if (rd !== 32'h0000_AB34) begin errors++; $display("FAIL div_lane1 got=%h exp=0000ab34", rd); end
    wb_xfer(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, rd, ak);
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL status_wr_ignored got=%h exp=0", rd); end
    wb_xfer(1'b1, BASE + 32'h8, 32'd0, 4'h3, rd, ak);
    wb_xfer(1'b1, BASE, 32'h5A, 4'h1, rd, ak);
    for (int i = 0; i < 10; i++) begin
      checks++; if (uart_tx !== exp_bit(8'h5A, 1, i, 1'b0, 1'b0)) begin
        errors++; $display("FAIL div0_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'h5A, 1, i, 1'b0, 1'b0)); end
      @(posedge clk); #1;
    end
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL div0_end busy=%b exp=0", dut.busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic        ak;
    wb_xfer(1'b1, BASE + 32'h8, 32'd4, 4'h3, rd, ak);
    wb_xfer(1'b1, BASE, 32'h00, 4'h1, rd, ak);
    repeat (10) @(posedge clk);
    #2;
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL areset_pre got=%b exp=0", uart_tx); end
    rstn = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL areset_tx got=%b exp=1", uart_tx); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (dut.busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++; $display("FAIL areset_state busy=%b tx=%b exp busy=0 tx=1", dut.busy, uart_tx); end
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
    checks++; if (rd !== 32'd347) begin errors++; $display("FAIL areset_div got=%0d exp=347", rd); end
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL areset_status got=%h exp=0", rd); end
  endtask

  task automatic test_parity();
    logic [31:0] rd;
    logic        ak;
    wb_xfer(1'b1, BASE + 32'h8, 32'd2, 4'h3, rd, ak);
`ifdef WB_UART_TX_PARITY_EN
    wb_xfer(1'b1, BASE + 32'hC, 32'h1, 4'h1, rd, ak);
    wb_xfer(1'b1, BASE, 32'h07, 4'h1, rd, ak);
    for (int i = 0; i < 22; i++) begin
      checks++; if (uart_tx !== exp_bit(8'h07, 2, i, 1'b1, 1'b0)) begin
        errors++; $display("FAIL even_par_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'h07, 2, i, 1'b1, 1'b0)); end
      @(posedge clk); #1;
    end
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL even_par_end busy=%b exp=0", dut.busy); end
    wb_xfer(1'b1, BASE + 32'hC, 32'h3, 4'h1, rd, ak);
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd, ak);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL ctrl_read got=%h exp=3", rd); end
    wb_xfer(1'b1, BASE, 32'h07, 4'h1, rd, ak);
    for (int i = 0; i < 22; i++) begin
      checks++; if (uart_tx !== exp_bit(8'h07, 2, i, 1'b1, 1'b1)) begin
        errors++; $display("FAIL odd_par_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'h07, 2, i, 1'b1, 1'b1)); end
      @(posedge clk); #1;
    end
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL odd_par_end busy=%b exp=0", dut.busy); end
`else
    wb_xfer(1'b1, BASE + 32'hC, 32'h3, 4'h1, rd, ak);
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd, ak);
    checks++; if (ak !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL ctrl_absent got=%h ack=%b exp=0", rd, ak); end
    wb_xfer(1'b1, BASE, 32'h07, 4'h1, rd, ak);
    for (int i = 0; i < 20; i++) begin
      checks++; if (uart_tx !== exp_bit(8'h07, 2, i, 1'b0, 1'b0)) begin
        errors++; $display("FAIL nopar_tx cyc=%0d got=%b exp=%b", i, uart_tx, exp_bit(8'h07, 2, i, 1'b0, 1'b0)); end
      @(posedge clk); #1;
    end
    checks++; if (dut.busy !== 1'b0) begin errors++; $display("FAIL nopar_end busy=%b exp=0", dut.busy); end
`endif
  endtask

  initial begin
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = 32'd0;
    wbs.wbs_dat_i = 32'd0;
    test_reset();
    test_frame();
    test_write_while_busy();
    test_div_midframe();
    test_div_lanes();
    test_async_reset();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
